// File: rtl/div_unit_if.sv
// div_unit_if: request/result bundle for the iterative divider.
//   start, signed_div, a, b, annul : requester -> divider
//   busy, done, quotient, remainder : divider -> requester
// The master modport is the requester (EX stage / bench); the slave modport
// is the divider.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             annul;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, signed_div, a, b, annul,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: restoring integer divider for MIPS DIV/DIVU, one quotient bit per
// cycle with a fixed latency of WIDTH+2 edges from the accepting edge to done.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   div    : div_unit_if.slave bundle
//            start/signed_div/a/b sampled on the accepting edge (IDLE/DONE),
//            annul cancels work in PREP/CALC and blocks start in IDLE/DONE,
//            busy high in PREP/CALC, done single-cycle pulse,
//            quotient (to LO) / remainder (to HI) held between completions.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         resetn,
  div_unit_if.slave    div
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Two's complement negate; the magnitude of the most negative value comes
  // out as the same bit pattern, which is correct when read as unsigned.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return {WIDTH{1'b0}} - v;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;          // dividend as sampled
  logic [WIDTH-1:0] b_q, b_d;          // divisor as sampled
  logic             sdiv_q, sdiv_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend magnitude, quotient bits shift in at LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [WIDTH-1:0] prem_q, prem_d;    // partial remainder (always < divisor)
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Trial subtract is one bit wider so its MSB is the borrow.
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   trial_s;
  logic             qbit_s;
  logic [WIDTH-1:0] prem_next_s;
  logic [WIDTH-1:0] quo_mag_s;

  // Shift in the next dividend bit and trial-subtract the divisor magnitude.
  always_comb begin
    shift_s     = {prem_q, dvd_q[WIDTH-1]};
    trial_s     = shift_s - {1'b0, dvs_q};
    qbit_s      = ~trial_s[WIDTH];
    if (qbit_s) begin
      prem_next_s = trial_s[WIDTH-1:0];
    end else begin
      prem_next_s = shift_s[WIDTH-1:0];
    end
    quo_mag_s   = {dvd_q[WIDTH-2:0], qbit_s};
  end

  // Next-state and datapath control for the IDLE/PREP/CALC/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sdiv_d  = sdiv_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    dbz_d   = dbz_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // annul outranks start; DONE accepts a new request back-to-back.
        if (div.annul) begin
          state_d = ST_IDLE;
        end else if (div.start) begin
          state_d = ST_PREP;
          a_d     = div.a;
          b_d     = div.b;
          sdiv_d  = div.signed_div;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PREP: begin
        if (div.annul) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CALC;
          dvd_d   = (sdiv_q && a_q[WIDTH-1]) ? negate(a_q) : a_q;
          dvs_d   = (sdiv_q && b_q[WIDTH-1]) ? negate(b_q) : b_q;
          qsign_d = sdiv_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rsign_d = sdiv_q & a_q[WIDTH-1];
          dbz_d   = (b_q == {WIDTH{1'b0}});
          prem_d  = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end
      end

      ST_CALC: begin
        if (div.annul) begin
          state_d = ST_IDLE;
        end else begin
          dvd_d  = quo_mag_s;
          prem_d = prem_next_s;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            // Results are loaded on the edge entering DONE so they line up with done.
            state_d = ST_DONE;
            if (dbz_q) begin
              quo_d = {WIDTH{1'b1}};
              rem_d = a_q;
            end else begin
              quo_d = qsign_q ? negate(quo_mag_s) : quo_mag_s;
              rem_d = rsign_q ? negate(prem_next_s) : prem_next_s;
            end
          end else begin
            state_d = ST_CALC;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_PREP) || (state_d == ST_CALC);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sdiv_q  <= 1'b0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      dbz_q   <= 1'b0;
      dvd_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      prem_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      quo_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sdiv_q  <= sdiv_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      dbz_q   <= dbz_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign div.busy      = busy_q;
  assign div.done      = done_q;
  assign div.quotient  = quo_q;
  assign div.remainder = rem_q;

endmodule
